// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM encoding and BRAM address stride
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  localparam int STRIDE = 4;
endpackage

// File: rtl/bram_stream_reader_stream_fifo.sv
// stream_fifo: synchronous FIFO allowing same-cycle push and pop
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = mem[rd];
  // storage write, no reset needed since count gates visibility
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: credit-gated sequential BRAM reader feeding a valid/ready stream
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_R_data,
  output logic [3:0]        m_W_req,
  output logic [DATA_W-1:0] m_W_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state;
  logic [LEN_W-1:0] len_q, issued;
  logic [ADDR_W-1:0] cur_addr, last_addr;
  logic [1:0] inflight;
  logic rd_pend, push, pop, drain_ok;
  logic [CW-1:0] count;
  logic fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_dout;
  assign m_W_req = 4'b0000;
  assign m_W_data = '0;
  assign m_en = state == ISSUE && issued < len_q && int'(count) + int'(inflight) < FIFO_DEPTH;
  assign m_addr = m_en ? cur_addr : last_addr;
  assign push = rd_pend && !fifo_full;
  assign pop = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_data = fifo_empty ? '0 : fifo_dout;
  assign drain_ok = int'(count) + int'(push) - int'(pop) == 0 && int'(inflight) == int'(push);
  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(m_R_data),
    .dout(fifo_dout),
    .count(count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  // job FSM plus read issue tracking; the read data lands one cycle after m_en
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      len_q <= '0;
      issued <= '0;
      cur_addr <= '0;
      last_addr <= '0;
      inflight <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= m_en;
      inflight <= inflight + 2'(m_en) - 2'(push);
      done <= 1'b0;
      if (m_en) begin
        last_addr <= cur_addr;
        cur_addr <= cur_addr + ADDR_W'(STRIDE);
        issued <= issued + LEN_W'(1);
      end
      case (state)
        IDLE:
          if (start) begin
            len_q <= len;
            issued <= '0;
            cur_addr <= base_addr;
            state <= len == '0 ? FIN : ISSUE;
            busy <= len != '0;
            done <= len == '0;
          end
        ISSUE:
          if (m_en && issued + LEN_W'(1) == len_q) state <= DRAIN;
        DRAIN:
          if (drain_ok) begin
            state <= FIN;
            busy <= 1'b0;
            done <= 1'b1;
          end
        default:
          state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed scenarios checked against a queue-based stream model
module tb_bram_stream_reader;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [31:0] base_addr = 0;
  logic [15:0] len = 0;
  logic busy, done, m_en, out_valid;
  logic [31:0] m_addr, m_W_data, out_data;
  logic [31:0] m_R_data = 0;
  logic [3:0] m_W_req;
  int checks = 0, errors = 0;
  int cyc = 0, e0 = 0, exp_done = -1, outstanding = 0;
  logic alt = 0, prev_stall = 0;
  logic [31:0] prev_data = 0;
  logic [31:0] exp_addr[$], exp_data[$], en_addr[$], hs_data[$];
  int en_cyc[$], hs_cyc[$], done_cyc[$];

  bram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .m_en(m_en), .m_addr(m_addr), .m_R_data(m_R_data),
    .m_W_req(m_W_req), .m_W_data(m_W_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_word(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // one-cycle-latency BRAM model
  always @(posedge clk) if (m_en) m_R_data <= bram_word(m_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // per-cycle comparison against the stream model
  always @(negedge clk) begin
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      exp_done = -1;
      outstanding = 0;
      prev_stall = 0;
    end else begin
      chk("w_req", {28'b0, m_W_req}, 32'h0);
      if (m_en) begin
        chk("credit", 32'(outstanding < 4), 32'h1);
        if (exp_addr.size() == 0) chk("unexpected_read", 32'h1, 32'h0);
        else chk("m_addr", m_addr, exp_addr.pop_front());
        en_addr.push_back(m_addr);
        en_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_valid", {31'b0, out_valid}, 32'h1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) chk("unexpected_word", 32'h1, 32'h0);
        else begin
          chk("out_data", out_data, exp_data.pop_front());
          if (exp_data.size() == 0) exp_done = cyc + 1;
        end
        hs_data.push_back(out_data);
        hs_cyc.push_back(cyc);
      end
      chk("done", {31'b0, done}, 32'(cyc == exp_done));
      if (done) done_cyc.push_back(cyc);
      outstanding += int'(m_en) - int'(out_valid && out_ready);
      chk("occupancy", 32'(outstanding <= 4), 32'h1);
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = alt ? ~out_ready : 1'b1;
  endtask

  task automatic clear_rec();
    en_addr.delete(); en_cyc.delete(); hs_data.delete(); hs_cyc.delete(); done_cyc.delete();
  endtask

  task automatic start_job(logic [31:0] a, logic [15:0] l);
    base_addr = a;
    len = l;
    start = 1;
    e0 = cyc;
    for (int k = 0; k < int'(l); k++) begin
      exp_addr.push_back(a + 32'(4 * k));
      exp_data.push_back(bram_word(a + 32'(4 * k)));
    end
    if (l == 0) exp_done = cyc + 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 32'h0, 32'h1);
    tick();
  endtask

  initial begin
    logic [31:0] s1_data[4] = '{32'hDEAD0100, 32'hDEAD0104, 32'hDEAD0108, 32'hDEAD010C};
    logic [31:0] s6_addr[4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    tick(); tick();
    rst = 0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_m_en", {31'b0, m_en}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    tick();

    clear_rec();
    start_job(32'h100, 4);
    chk("s1_busy", {31'b0, busy}, 1);
    wait_done(40);
    chk("s1_reads", en_addr.size(), 4);
    chk("s1_words", hs_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("s1_addr", en_addr[k], 32'h100 + 32'(4 * k));
      chk("s1_en_cyc", en_cyc[k], e0 + 1 + k);
      chk("s1_word", hs_data[k], s1_data[k]);
      chk("s1_hs_cyc", hs_cyc[k], e0 + 3 + k);
    end
    chk("s1_done_cnt", done_cyc.size(), 1);
    chk("s1_done_cyc", done_cyc[0], e0 + 7);
    tick();

    clear_rec();
    alt = 1;
    out_ready = 1;
    start_job(32'h100, 4);
    wait_done(60);
    alt = 0;
    out_ready = 1;
    chk("s2_words", hs_data.size(), 4);
    for (int k = 0; k < 4; k++) chk("s2_word", hs_data[k], s1_data[k]);
    chk("s2_done_cnt", done_cyc.size(), 1);
    tick();

    clear_rec();
    start_job(32'h180, 0);
    tick(); tick(); tick();
    chk("s3_reads", en_addr.size(), 0);
    chk("s3_words", hs_data.size(), 0);
    chk("s3_done_cnt", done_cyc.size(), 1);
    chk("s3_done_cyc", done_cyc[0], e0 + 1);

    clear_rec();
    start_job(32'h200, 8);
    for (int p = 0; p < 3; p++) begin
      base_addr = 32'h900;
      len = 3;
      start = 1;
      tick();
      start = 0;
      tick();
    end
    wait_done(60);
    tick(); tick();
    chk("s4_words", hs_data.size(), 8);
    chk("s4_last", hs_data[7], bram_word(32'h21C));
    chk("s4_done_cnt", done_cyc.size(), 1);

    clear_rec();
    start_job(32'h300, 6);
    for (int n = 0; n < 30 && hs_data.size() < 2; n++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("s5_busy", {31'b0, busy}, 0);
    chk("s5_m_en", {31'b0, m_en}, 0);
    chk("s5_out_valid", {31'b0, out_valid}, 0);
    chk("s5_done", {31'b0, done}, 0);
    tick(); tick();
    clear_rec();
    start_job(32'h400, 2);
    wait_done(40);
    chk("s5_words", hs_data.size(), 2);
    chk("s5_w0", hs_data[0], 32'hDEAD0400);
    chk("s5_w1", hs_data[1], 32'hDEAD0404);
    chk("s5_done_cnt", done_cyc.size(), 1);
    tick();

    clear_rec();
    start_job(32'hFFFFFFF8, 4);
    wait_done(40);
    chk("s6_reads", en_addr.size(), 4);
    for (int k = 0; k < 4; k++) chk("s6_addr", en_addr[k], s6_addr[k]);
    chk("s6_words", hs_data.size(), 4);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
